// File: rtl/up_down_mod_counter.sv
// ---------------------------------------------------------------------------
// up_down_mod_counter
//   Up/down counter over the inclusive range 0..limit_i with selectable
//   wrap (modulo) or saturate behaviour at the range boundaries.
//
// Parameters
//   BUS_WIDTH : counter width in bits (2..32)
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst_n_i  in   asynchronous active-low reset
//   clr_i    in   synchronous clear (highest priority)
//   load_i   in   synchronous load of min(data_i, limit_i)
//   data_i   in   parallel load value
//   e_i      in   count enable
//   d_i      in   direction: 0 = up, 1 = down
//   sat_i    in   boundary mode: 0 = wrap, 1 = saturate
//   limit_i  in   inclusive maximum count
//   data_o   out  registered count value
//   cout     out  registered one-cycle boundary pulse
//   ovf_o    out  registered sticky boundary flag
//   zero_o   out  combinational (data_o == 0)
// ---------------------------------------------------------------------------
module up_down_mod_counter #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [BUS_WIDTH-1:0] data_i,
    input  logic                 e_i,
    input  logic                 d_i,
    input  logic                 sat_i,
    input  logic [BUS_WIDTH-1:0] limit_i,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 cout,
    output logic                 ovf_o,
    output logic                 zero_o
);

    localparam logic [BUS_WIDTH-1:0] ZERO_C = {BUS_WIDTH{1'b0}};
    localparam logic [BUS_WIDTH-1:0] ONE_C  = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

    logic [BUS_WIDTH-1:0] count_r;
    logic                 cout_r;
    logic                 ovf_r;

    logic [BUS_WIDTH-1:0] count_nxt_s;
    logic                 cout_nxt_s;
    logic                 ovf_nxt_s;

    // Next-state selection: clear, then load, then count, then hold.
    always_comb begin
        count_nxt_s = count_r;
        cout_nxt_s  = 1'b0;
        ovf_nxt_s   = ovf_r;
        if (clr_i) begin
            count_nxt_s = ZERO_C;
            ovf_nxt_s   = 1'b0;
        end else if (load_i) begin
            // Clamp the load value into the legal range.
            count_nxt_s = (data_i > limit_i) ? limit_i : data_i;
            ovf_nxt_s   = 1'b0;
        end else if (e_i) begin
            if (!d_i) begin
                // ">=" so a count left above a lowered limit is a boundary.
                if (count_r >= limit_i) begin
                    count_nxt_s = sat_i ? limit_i : ZERO_C;
                    cout_nxt_s  = 1'b1;
                    ovf_nxt_s   = 1'b1;
                end else begin
                    count_nxt_s = count_r + ONE_C;
                end
            end else begin
                if (count_r == ZERO_C) begin
                    count_nxt_s = sat_i ? ZERO_C : limit_i;
                    cout_nxt_s  = 1'b1;
                    ovf_nxt_s   = 1'b1;
                end else begin
                    count_nxt_s = count_r - ONE_C;
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_r <= ZERO_C;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            cout_r  <= cout_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign data_o = count_r;
    assign cout   = cout_r;
    assign ovf_o  = ovf_r;
    assign zero_o = (count_r == ZERO_C);

endmodule

// File: doc/up_down_mod_counter.md
UP_DOWN_MOD_COUNTER -- requirements
Module: up_down_mod_counter

Interface
REQ-001 The block SHALL have one parameter: BUS_WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk is the clock and rst_n_i is the reset.
REQ-003 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n_i  input  1  asynchronous active-low reset.
REQ-005 Port clr_i  input  1  synchronous clear.
REQ-006 Port load_i  input  1  synchronous parallel load of data_i.
REQ-007 Port data_i  input  BUS_WIDTH  parallel load value.
REQ-008 Port e_i  input  1  count enable.
REQ-009 Port d_i  input  1  direction: 0 = up, 1 = down.
REQ-010 Port sat_i  input  1  boundary mode: 0 = wrap (modulo), 1 = saturate.
REQ-011 Port limit_i  input  BUS_WIDTH  inclusive maximum count; the count range is 0..limit_i.
REQ-012 Port data_o  output  BUS_WIDTH  registered count value.
REQ-013 Port cout  output  1  registered one-cycle boundary pulse.
REQ-014 Port ovf_o  output  1  registered sticky boundary flag.
REQ-015 Port zero_o  output  1  combinational flag, equal to (data_o == 0).

Function
REQ-016 Per edge, the block SHALL apply exactly one action, in this priority: clr_i, then load_i, then e_i, then hold.
REQ-017 When clr_i=1, the block SHALL set data_o=0, cout=0 and ovf_o=0.
REQ-018 When load_i=1 and clr_i=0, the block SHALL set data_o = min(data_i, limit_i), cout=0 and ovf_o=0.
REQ-019 When clr_i=0, load_i=0 and e_i=0, the block SHALL hold data_o and ovf_o and set cout=0.
REQ-020 Up step with data_o < limit_i: the block SHALL set data_o = data_o+1 and cout=0.
REQ-021 Up step with data_o >= limit_i (boundary): wrap mode SHALL set data_o=0; saturate mode SHALL set data_o=limit_i.
REQ-022 Down step with data_o > 0: the block SHALL set data_o = data_o-1 and cout=0.
REQ-023 Down step with data_o == 0 (boundary): wrap mode SHALL set data_o=limit_i; saturate mode SHALL hold 0.
REQ-024 On any boundary step, the block SHALL set cout=1 for the following cycle and set ovf_o=1.
REQ-025 ovf_o SHALL remain 1 until clr_i, load_i or reset.
REQ-026 In saturate mode, each further enabled step against the boundary SHALL again produce cout=1, so cout stays high while blocked.
REQ-027 If limit_i is lowered below the current data_o, the next up step SHALL be a boundary step, and a down step SHALL decrement normally.
REQ-028 When limit_i=0, every enabled step SHALL be a boundary step and data_o SHALL stay 0.
REQ-029 limit_i = 2^BUS_WIDTH-1 SHALL give full binary range, with wrap from all-ones to 0 and back.
REQ-030 A change of d_i, sat_i or limit_i SHALL take effect on the first edge it is sampled at; no pipeline latency is permitted.
REQ-031 All arithmetic SHALL be BUS_WIDTH-bit unsigned with no internal overflow beyond the rules above.

Reset
REQ-032 While rst_n_i=0, the block SHALL hold data_o=0, cout=0 and ovf_o=0, independent of clk.
REQ-033 Reset assertion mid-count SHALL take effect immediately, without waiting for a clock edge.
REQ-034 The first edge after rst_n_i rises SHALL apply REQ-016 normally.

Verification
REQ-035 The bench SHALL cover: reset, then limit_i=5, sat_i=0, d_i=0, e_i=1 for 8 cycles -> data_o 1,2,3,4,5,0,1,2; cout high only in the cycle data_o=0; ovf_o=1 afterwards.
REQ-036 The bench SHALL cover: limit_i=5, sat_i=1, d_i=1, starting from data_o=1, e_i=1 for 4 cycles -> data_o 0,0,0,0; cout low, then high, high, high; zero_o=1.
REQ-037 The bench SHALL cover: load_i=1, data_i=9, limit_i=6, with e_i=1 asserted in the same cycle -> data_o=6, cout=0, ovf_o cleared; the load wins over the count.
REQ-038 The bench SHALL cover: clr_i=1 and load_i=1 together with data_o=3 -> data_o=0 and ovf_o=0.
REQ-039 The bench SHALL cover: BUS_WIDTH=8, limit_i=255, data_o=255, up step in wrap mode -> data_o=0 and cout=1; then a down step -> data_o=255 and cout=1.
REQ-040 The bench SHALL cover: data_o=7, then limit_i changed to 3, then an up step in wrap mode -> data_o=0; assert rst_n_i=0 between clock edges -> data_o=0 immediately.
